// File: rtl/axi_default_slave_burst.sv
// Default AXI slave: accepts every read/write burst and answers each beat with RESP_CODE.
// Independent read and write FSMs; ERR_CNT counts accepted address handshakes, saturating.
module axi_default_slave_burst #(
  parameter int         ID_W      = 8,
  parameter int         LEN_W     = 8,
  parameter int         DATA_W    = 32,
  parameter logic [1:0] RESP_CODE = 2'b11,
  parameter int         CNT_W     = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   AWID,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic              WVALID,
  input  logic              WLAST,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [CNT_W-1:0]  ERR_CNT
);

  typedef enum logic       {R_IDLE, R_BURST}         r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;

  r_state_t         r_state, r_next;
  w_state_t         w_state, w_next;
  logic [LEN_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_id, w_id;
  logic             ar_hs, aw_hs;
  logic [CNT_W:0]   cnt_sum;

  // Write length is irrelevant: WLAST alone ends the data phase.
  logic unused_awlen;
  assign unused_awlen = ^AWLEN;

  // ---------------- read channel ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_cnt <= ARLEN;
        r_id  <= ARID;
      end else if (RVALID && RREADY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    ar_hs   = 1'b0;
    RVALID  = 1'b0;
    RID     = '0;
    RDATA   = '0;
    RRESP   = 2'b00;
    RLAST   = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        ar_hs   = ARVALID;
        if (ARVALID) r_next = R_BURST;
      end
      R_BURST: begin
        RVALID = 1'b1;
        RID    = r_id;
        RRESP  = RESP_CODE;
        RLAST  = (r_cnt == '0);
        if (RREADY && r_cnt == '0) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // ---------------- write channel ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      w_id    <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) w_id <= AWID;
    end
  end

  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    aw_hs   = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BID     = '0;
    BRESP   = 2'b00;
    case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        aw_hs   = AWVALID;
        if (AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && WLAST) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BID    = w_id;
        BRESP  = RESP_CODE;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // ---------------- error counter ----------------
  // One extra bit catches overflow so a +2 step near the top still clamps.
  assign cnt_sum = {1'b0, ERR_CNT} + {{CNT_W{1'b0}}, ar_hs} + {{CNT_W{1'b0}}, aw_hs};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)            ERR_CNT <= '0;
    else if (cnt_sum[CNT_W]) ERR_CNT <= '1;
    else                     ERR_CNT <= cnt_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_axi_default_slave_burst.sv
// Scoreboard bench for axi_default_slave_burst; a CNT_W=2 twin shares the inputs
// to exercise ERR_CNT saturation.
module tb_axi_default_slave_burst;
  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic [7:0]  AWID = '0, AWLEN = '0, ARID = '0, ARLEN = '0;
  logic        AWVALID = 0, WVALID = 0, WLAST = 0, BREADY = 1, ARVALID = 0, RREADY = 1;
  logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
  logic [7:0]  BID, RID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic [15:0] ERR_CNT;
  logic        s_AWREADY, s_WREADY, s_BVALID, s_ARREADY, s_RLAST, s_RVALID;
  logic [7:0]  s_BID, s_RID;
  logic [1:0]  s_BRESP, s_RRESP;
  logic [31:0] s_RDATA;
  logic [1:0]  s_ERR_CNT;

  always #5 ACLK = ~ACLK;

  axi_default_slave_burst dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .ERR_CNT(ERR_CNT));

  axi_default_slave_burst #(.CNT_W(2)) dut_sat (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(s_AWREADY),
    .WVALID(WVALID), .WLAST(WLAST), .WREADY(s_WREADY),
    .BID(s_BID), .BRESP(s_BRESP), .BVALID(s_BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(s_ARREADY),
    .RID(s_RID), .RDATA(s_RDATA), .RRESP(s_RRESP), .RLAST(s_RLAST), .RVALID(s_RVALID), .RREADY(RREADY),
    .ERR_CNT(s_ERR_CNT));

  typedef struct packed { logic [7:0] id; logic last; } rexp_t;
  rexp_t      r_q[$];
  logic [7:0] b_q[$];
  int n_cmp = 0, n_err = 0, exp_cnt = 0, r_beats = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pop expectations on each accepted beat, check idle zeros and stall holds.
  rexp_t       e;
  logic [7:0]  be;
  logic        r_hold_v = 0, b_hold_v = 0;
  logic [11:0] r_hold;
  logic [10:0] b_hold;
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      r_hold_v = 0;
      b_hold_v = 0;
    end else begin
      if (RVALID && RREADY) begin
        r_beats++;
        if (r_q.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          e = r_q.pop_front();
          chk("r_beat", {RID, RLAST, RRESP, RDATA}, {e.id, e.last, 2'b11, 32'h0});
        end
      end else if (!RVALID) chk("r_idle_zero", {RID, RDATA, RRESP, RLAST}, 0);
      if (r_hold_v) chk("r_hold", {RVALID, RID, RLAST, RRESP}, r_hold);
      r_hold_v = RVALID && !RREADY;
      r_hold   = {RVALID, RID, RLAST, RRESP};

      if (BVALID && BREADY) begin
        if (b_q.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          be = b_q.pop_front();
          chk("b_beat", {BID, BRESP}, {be, 2'b11});
        end
      end else if (!BVALID) chk("b_idle_zero", {BID, BRESP}, 0);
      if (b_hold_v) chk("b_hold", {BVALID, BID, BRESP}, b_hold);
      b_hold_v = BVALID && !BREADY;
      b_hold   = {BVALID, BID, BRESP};
    end
  end

  // All drive tasks start and end at posedge+1.
  task automatic do_ar(input logic [7:0] id, input logic [7:0] len, output int waited);
    int n = 0;
    ARVALID = 1; ARID = id; ARLEN = len;
    @(negedge ACLK);
    while (!ARREADY && n < 100) begin @(negedge ACLK); n++; end
    chk("ar_accepted", n < 100, 1);
    for (int i = 0; i <= int'(len); i++) r_q.push_back({id, i == int'(len)});
    exp_cnt++;
    waited = n;
    @(posedge ACLK); #1;
    ARVALID = 0;
  endtask

  task automatic do_aw(input logic [7:0] id, input int nb);
    int n = 0;
    AWVALID = 1; AWID = id;
    @(negedge ACLK);
    while (!AWREADY && n < 100) begin @(negedge ACLK); n++; end
    chk("aw_accepted", n < 100, 1);
    b_q.push_back(id);
    exp_cnt++;
    @(posedge ACLK); #1;
    AWVALID = 0;
    for (int i = 0; i < nb; i++) begin
      WVALID = 1; WLAST = (i == nb - 1);
      n = 0;
      @(negedge ACLK);
      while (!WREADY && n < 100) begin @(negedge ACLK); n++; end
      chk("w_accepted", n < 100, 1);
      @(posedge ACLK); #1;
    end
    WVALID = 0; WLAST = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && n < 200) begin @(negedge ACLK); n++; end
    chk("drain", r_q.size() + b_q.size(), 0);
    @(posedge ACLK); #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt"}, ERR_CNT, exp_cnt);
    chk({tag, "_cnt_sat"}, s_ERR_CNT, (exp_cnt > 3) ? 3 : exp_cnt);
  endtask

  initial begin
    int w, rb, n;
    // reset state
    #3;
    chk("rst_ready", {ARREADY, AWREADY}, 2'b11);
    chk("rst_outs", {RVALID, WREADY, BVALID, RID, RDATA, RRESP, RLAST, BID, BRESP}, 0);
    chk("rst_cnt", ERR_CNT, 0);
    #9 ARESETn = 1;
    @(posedge ACLK); #1;

    // 4-beat read, RREADY high
    rb = r_beats;
    do_ar(8'h5A, 8'd3, w);
    drain();
    chk("rd4_beats", r_beats - rb, 4);
    chk_cnt("rd4");

    // 2-beat read with RREADY 1,0,0,1
    rb = r_beats;
    do_ar(8'h11, 8'd1, w);
    @(posedge ACLK); #1 RREADY = 0;
    @(posedge ACLK);
    @(posedge ACLK); #1 RREADY = 1;
    drain();
    chk("rd2_beats", r_beats - rb, 2);

    // W beat before AW must stall
    WVALID = 1;
    @(negedge ACLK) chk("w_stall", WREADY, 0);
    @(negedge ACLK) chk("w_stall", WREADY, 0);
    @(posedge ACLK); #1;

    // write burst with BREADY delayed 2 cycles
    BREADY = 0;
    do_aw(8'h33, 3);
    n = 0;
    while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
    chk("bvalid_up", BVALID, 1);
    @(negedge ACLK) chk("bvalid_held", {BVALID, BID, BRESP}, {1'b1, 8'h33, 2'b11});
    @(negedge ACLK) chk("bvalid_held", {BVALID, BID, BRESP}, {1'b1, 8'h33, 2'b11});
    @(posedge ACLK); #1 BREADY = 1;
    drain();
    chk_cnt("wr");

    // back-to-back single-beat reads: second AR accepted right after return to idle
    do_ar(8'h21, 8'd0, w);
    do_ar(8'h22, 8'd0, w);
    chk("b2b_wait", w, 1);
    drain();

    // simultaneous AR/AW pushing the 2-bit twin into saturation
    #2 ARESETn = 0;
    exp_cnt = 0;
    @(posedge ACLK); #2 ARESETn = 1;
    @(posedge ACLK); #1;
    do_ar(8'h01, 8'd0, w);
    do_aw(8'h02, 1);
    drain();
    chk_cnt("pre");
    fork
      do_ar(8'h44, 8'd2, w);
      do_aw(8'h55, 2);
    join
    drain();
    chk_cnt("both");

    // reset during beat 2 of an 8-beat read
    rb = r_beats;
    do_ar(8'h77, 8'd7, w);
    @(posedge ACLK); #2;
    ARESETn = 0;
    #1;
    chk("abort_rvalid", RVALID, 0);
    chk("abort_arready", ARREADY, 1);
    chk("abort_cnt", ERR_CNT, 0);
    r_q.delete();
    exp_cnt = 0;
    @(posedge ACLK); #2 ARESETn = 1;
    repeat (10) @(negedge ACLK);
    chk("abort_no_beats", r_beats - rb, 1);
    chk("abort_idle", {RVALID, ARREADY}, 2'b01);
    chk_cnt("abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_default_slave_burst.md
AXI_DEFAULT_SLAVE_BURST -- requirements
Module: axi_default_slave_burst

Interface
REQ-001 The block SHALL have parameter ID_W, default 8, meaning AXI ID width.
REQ-002 The block SHALL have parameter LEN_W, default 8, meaning AxLEN width (beats = AxLEN+1).
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning RDATA width.
REQ-004 The block SHALL have parameter RESP_CODE, default 2'b11, meaning response returned on every B/R beat (DECERR).
REQ-005 The block SHALL have parameter CNT_W, default 16, meaning ERR_CNT width.
REQ-006 The block SHALL have ports (name  direction  width  meaning):
- ACLK  in  1  clock, rising edge
- ARESETn  in  1  reset, asynchronous, active-low
- AWID  in  ID_W  write address ID
- AWLEN  in  LEN_W  write burst length (ignored; WLAST governs)
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WVALID  in  1  write data valid
- WLAST  in  1  last write beat
- WREADY  out  1  write data ready
- BID  out  ID_W  response ID
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARID  in  ID_W  read address ID
- ARLEN  in  LEN_W  read burst length
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RID  out  ID_W  read ID
- RDATA  out  DATA_W  read data
- RRESP  out  2  read response
- RLAST  out  1  last read beat
- RVALID  out  1  read valid
- RREADY  in  1  read ready
- ERR_CNT  out  CNT_W  saturating count of decode-error transactions accepted

Function
REQ-007 Read FSM SHALL have states R_IDLE, R_BURST; write FSM SHALL have states W_IDLE, W_DATA, W_RESP; the two FSMs SHALL be independent.
REQ-008 R_IDLE: ARREADY=1, RVALID=0; on ARVALID SHALL register ARID and beat counter=ARLEN, go to R_BURST.
REQ-009 R_BURST: ARREADY=0, RVALID=1, RID=registered ID, RDATA=0, RRESP=RESP_CODE, RLAST=(counter==0).
REQ-010 In R_BURST, on RVALID&RREADY: counter==0 -> R_IDLE, else counter decrements; with RREADY low all R outputs SHALL hold.
REQ-011 First RVALID SHALL assert the cycle after the AR handshake; an ARLEN=L burst SHALL deliver exactly L+1 beats, RLAST only on the last.
REQ-012 W_IDLE: AWREADY=1, WREADY=0, BVALID=0; on AWVALID SHALL register AWID, go to W_DATA.
REQ-013 W_DATA: AWREADY=0, WREADY=1; every WVALID beat SHALL be accepted and discarded; WVALID&WLAST -> W_RESP.
REQ-014 W_RESP: WREADY=0, BVALID=1, BID=registered ID, BRESP=RESP_CODE; BREADY -> W_IDLE.
REQ-015 W beats arriving in W_IDLE SHALL stall (WREADY=0) until the AW handshake.
REQ-016 When not valid, RID, RDATA, RRESP, RLAST, BID, BRESP SHALL be 0.
REQ-017 ERR_CNT SHALL increment by 1 per AR handshake and per AW handshake, by 2 when both occur in the same cycle, and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-018 Back-to-back: a new AR/AW SHALL be accepted in the cycle after returning to the idle state, no bubble beyond that.

Reset
REQ-019 ARESETn low SHALL force R_IDLE, W_IDLE, counters, registered IDs, ERR_CNT to 0 immediately, independent of ACLK.
REQ-020 During and after reset, ARREADY=1, AWREADY=1, all other outputs 0.
REQ-021 Reset mid-burst or mid-response SHALL abort the transaction; no further R/B beats SHALL be issued for it.

Verification
REQ-022 AR ID=0x5A, ARLEN=3, RREADY=1 -> 4 RVALID beats, RID=0x5A, RRESP=2'b11, RLAST on beat 4 only, ERR_CNT=1.
REQ-023 AR ARLEN=1 with RREADY toggling 1,0,0,1 -> outputs held during stall, exactly 2 beats accepted.
REQ-024 AW ID=0x33, 3 W beats with WLAST on third, BREADY delayed 2 cycles -> BVALID held, BID=0x33, BRESP=2'b11.
REQ-025 AR and AW handshake in the same cycle, CNT_W=2 preloaded to 2 -> ERR_CNT=3 (saturated), both channels complete.
REQ-026 ARESETn pulsed low in beat 2 of ARLEN=7 burst -> RVALID=0 immediately, ARREADY=1, ERR_CNT=0.
